// File: rtl/johnson_decode_monitor_pkg.sv
// Shared definitions for the Johnson-code monitor.
//   state_t        : monitor FSM states (HUNT searches for lock, TRACK follows it)
//   johnson_legal  : 1 when the low n bits of q form a Johnson code
//   johnson_index  : position (0..2n-1) of a legal Johnson code in the sequence
// The helpers take a MAX_N-wide vector plus the live width n, so one package
// serves every counter width up to MAX_N (RTL decoder and bench scoreboards).
package johnson_decode_monitor_pkg;

  localparam int MAX_N = 32;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  function automatic logic [MAX_N-1:0] johnson_mask(input int n);
    logic [MAX_N-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Legal iff q or ~q is a contiguous run of ones starting at bit 0
  // (including all-zeros), evaluated with n-bit arithmetic.
  function automatic logic johnson_legal(input logic [MAX_N-1:0] q, input int n);
    logic [MAX_N-1:0] m;
    logic [MAX_N-1:0] qm;
    logic [MAX_N-1:0] qn;
    m  = johnson_mask(n);
    qm = q & m;
    qn = ~q & m;
    return (((qm & (qm + 1'b1)) & m) == '0) || (((qn & (qn + 1'b1)) & m) == '0);
  endfunction

  // Ones fill from bit 0 during the first half of the cycle, then drain from
  // bit 0 during the second half; the MSB tells the two halves apart.
  function automatic int johnson_index(input logic [MAX_N-1:0] q, input int n);
    int pop;
    logic [MAX_N-1:0] qm;
    qm  = q & johnson_mask(n);
    pop = 0;
    for (int i = 0; i < MAX_N; i++) begin
      pop += int'(qm[i]);
    end
    if (n > 0 && qm[n-1]) return 2 * n - pop;
    return pop;
  endfunction

endpackage

// File: rtl/johnson_decode_monitor_code_decode.sv
// johnson_code_decode: purely combinational Johnson code classifier.
//   q     : N-bit Johnson state
//   legal : 1 when q is a valid Johnson code
//   idx   : decoded sequence index (meaningful only when legal=1)
module johnson_code_decode
  import johnson_decode_monitor_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = $clog2(2 * N)
) (
  input  logic [N-1:0]     q,
  output logic             legal,
  output logic [CNT_W-1:0] idx
);

  logic [MAX_N-1:0] q_ext;

  always_comb begin
    q_ext = MAX_N'(q);
    legal = johnson_legal(q_ext, N);
    idx   = CNT_W'(johnson_index(q_ext, N));
  end

endmodule

// File: rtl/johnson_decode_monitor.sv
// johnson_decode_monitor: checks and decodes a Johnson counter state stream.
//   clk, rst    : clock, synchronous active-high reset
//   en          : sample enable for q
//   q           : N-bit Johnson state
//   clr_err     : synchronous clear of err_cnt (wins over a same-cycle increment)
//   count       : decoded index of the last legal sample
//   count_valid : pulse, legal sample accepted
//   illegal     : pulse, sample was not a Johnson code
//   seq_err     : pulse, legal but out-of-sequence sample while locked
//   locked      : FSM is in TRACK
//   wrap        : pulse, locked transition 2N-1 -> 0
//   err_cnt     : saturating count of errors seen while locked
//   fsm_state   : debug view of the FSM state
// Handshake: en is a plain qualifier; no backpressure, one sample per en=1 cycle.
module johnson_decode_monitor
  import johnson_decode_monitor_pkg::*;
#(
  parameter int N        = 4,
  parameter int LOCK_LEN = 2,
  parameter int ERR_W    = 8,
  localparam int CNT_W   = $clog2(2 * N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     q,
  input  logic             clr_err,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             illegal,
  output logic             seq_err,
  output logic             locked,
  output logic             wrap,
  output logic [ERR_W-1:0] err_cnt,
  output state_t           fsm_state
);

  localparam int RUN_W = $clog2(LOCK_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(2 * N - 1);

  logic             legal;
  logic [CNT_W-1:0] idx;

  johnson_code_decode #(.N(N), .CNT_W(CNT_W)) u_decode (
    .q     (q),
    .legal (legal),
    .idx   (idx)
  );

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             count_valid_q, count_valid_d;
  logic             illegal_q, illegal_d;
  logic             seq_err_q, seq_err_d;
  logic             wrap_q, wrap_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [CNT_W-1:0] exp_idx;
  logic [RUN_W:0]   run_inc;
  logic             err_inc;

  always_comb begin
    state_d       = state_q;
    run_d         = run_q;
    prev_d        = prev_q;
    count_d       = count_q;
    count_valid_d = 1'b0;
    illegal_d     = 1'b0;
    seq_err_d     = 1'b0;
    wrap_d        = 1'b0;
    err_inc       = 1'b0;

    // Explicit wrap so non-power-of-two 2N sequences close correctly.
    exp_idx = (prev_q == LAST_IDX) ? '0 : prev_q + CNT_W'(1);
    run_inc = {1'b0, run_q} + (RUN_W + 1)'(1);

    if (en) begin
      if (legal) begin
        count_d       = idx;
        count_valid_d = 1'b1;
        prev_d        = idx;
      end
      unique case (state_q)
        HUNT: begin
          if (!legal) begin
            illegal_d = 1'b1;
            run_d     = '0;
          end else if (run_q == '0 || idx == exp_idx) begin
            run_d = run_inc[RUN_W-1:0];
            if (run_inc >= (RUN_W + 1)'(LOCK_LEN)) state_d = TRACK;
          end else begin
            // Out-of-sequence sample still starts a fresh run.
            run_d = RUN_W'(1);
          end
        end
        TRACK: begin
          if (!legal) begin
            illegal_d = 1'b1;
            err_inc   = 1'b1;
            run_d     = '0;
            state_d   = HUNT;
          end else if (idx != exp_idx) begin
            seq_err_d = 1'b1;
            err_inc   = 1'b1;
            run_d     = RUN_W'(1);
            state_d   = HUNT;
          end else begin
            wrap_d = (prev_q == LAST_IDX) && (idx == '0);
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (clr_err) begin
      err_cnt_d = '0;
    end else if (err_inc && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      run_q         <= '0;
      prev_q        <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      wrap_q        <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      prev_q        <= prev_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      illegal_q     <= illegal_d;
      seq_err_q     <= seq_err_d;
      wrap_q        <= wrap_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign count       = count_q;
  assign count_valid = count_valid_q;
  assign illegal     = illegal_q;
  assign seq_err     = seq_err_q;
  assign wrap        = wrap_q;
  assign err_cnt     = err_cnt_q;
  assign locked      = (state_q == TRACK);
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_johnson_decode_monitor.sv
// Directed bench for johnson_decode_monitor with N=4, LOCK_LEN=2, ERR_W=2.
module tb_johnson_decode_monitor;
  import johnson_decode_monitor_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] q;
  logic       clr_err;
  logic [2:0] count;
  logic       count_valid;
  logic       illegal;
  logic       seq_err;
  logic       locked;
  logic       wrap;
  logic [1:0] err_cnt;
  state_t     fsm_state;

  int checks = 0;
  int errors = 0;

  johnson_decode_monitor #(.N(4), .LOCK_LEN(2), .ERR_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .q           (q),
    .clr_err     (clr_err),
    .count       (count),
    .count_valid (count_valid),
    .illegal     (illegal),
    .seq_err     (seq_err),
    .locked      (locked),
    .wrap        (wrap),
    .err_cnt     (err_cnt),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic step(input logic [3:0] qv, input logic env, input logic clrv, input logic rstv);
    q       = qv;
    en      = env;
    clr_err = clrv;
    rst     = rstv;
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input logic [3:0] qv);
    step(qv, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic expect_out(input string tag, input logic [2:0] c, input logic cv,
                            input logic ill, input logic se, input logic lk,
                            input logic wr, input logic [1:0] ec);
    checks++;
    assert (count === c) else begin
      errors++; $error("FAIL %s count got %0d exp %0d", tag, count, c);
    end
    checks++;
    assert (count_valid === cv) else begin
      errors++; $error("FAIL %s count_valid got %0b exp %0b", tag, count_valid, cv);
    end
    checks++;
    assert (illegal === ill) else begin
      errors++; $error("FAIL %s illegal got %0b exp %0b", tag, illegal, ill);
    end
    checks++;
    assert (seq_err === se) else begin
      errors++; $error("FAIL %s seq_err got %0b exp %0b", tag, seq_err, se);
    end
    checks++;
    assert (locked === lk) else begin
      errors++; $error("FAIL %s locked got %0b exp %0b", tag, locked, lk);
    end
    checks++;
    assert (wrap === wr) else begin
      errors++; $error("FAIL %s wrap got %0b exp %0b", tag, wrap, wr);
    end
    checks++;
    assert (err_cnt === ec) else begin
      errors++; $error("FAIL %s err_cnt got %0d exp %0d", tag, err_cnt, ec);
    end
  endtask

  // Johnson sequence for N=4, index 0..7
  logic [3:0] seq [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                          4'b1111, 4'b1110, 4'b1100, 4'b1000};

  initial begin
    rst = 1'b1; en = 1'b0; q = '0; clr_err = 1'b0;
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    expect_out("reset", 3'd0, 0, 0, 0, 0, 0, 2'd0);
    checks++;
    assert (fsm_state === HUNT) else begin
      errors++; $error("FAIL reset_state got %0d exp %0d", fsm_state, HUNT);
    end

    // 1: full sequence, lock after index 1, wrap on the return to 0000
    samp(seq[0]); expect_out("s1_i0", 3'd0, 1, 0, 0, 0, 0, 2'd0);
    samp(seq[1]); expect_out("s1_i1", 3'd1, 1, 0, 0, 1, 0, 2'd0);
    for (int i = 2; i < 8; i++) begin
      samp(seq[i]);
      expect_out($sformatf("s1_i%0d", i), 3'(i), 1, 0, 0, 1, 0, 2'd0);
    end
    samp(4'b0000); expect_out("s1_wrap", 3'd0, 1, 0, 0, 1, 1, 2'd0);

    // 2: illegal while locked at index 2, then relock
    samp(4'b0001); samp(4'b0011);
    expect_out("s2_at2", 3'd2, 1, 0, 0, 1, 0, 2'd0);
    samp(4'b0101); expect_out("s2_illegal", 3'd2, 0, 1, 0, 0, 0, 2'd1);
    samp(4'b0111); expect_out("s2_hunt3", 3'd3, 1, 0, 0, 0, 0, 2'd1);
    samp(4'b1111); expect_out("s2_relock", 3'd4, 1, 0, 0, 1, 0, 2'd1);

    // 3: sequence break from index 2 to index 4
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    samp(4'b0001); samp(4'b0011);
    expect_out("s3_at2", 3'd2, 1, 0, 0, 1, 0, 2'd0);
    samp(4'b1111); expect_out("s3_seqerr", 3'd4, 1, 0, 1, 0, 0, 2'd1);
    samp(4'b1110); expect_out("s3_relock", 3'd5, 1, 0, 0, 1, 0, 2'd1);

    // 4: en=0 holds state while q wanders
    step(4'b0101, 1'b0, 1'b0, 1'b0); expect_out("s4_hold0", 3'd5, 0, 0, 0, 1, 0, 2'd1);
    step(4'b0000, 1'b0, 1'b0, 1'b0); expect_out("s4_hold1", 3'd5, 0, 0, 0, 1, 0, 2'd1);
    step(4'b1111, 1'b0, 1'b0, 1'b0); expect_out("s4_hold2", 3'd5, 0, 0, 0, 1, 0, 2'd1);
    samp(4'b1100); expect_out("s4_resume", 3'd6, 1, 0, 0, 1, 0, 2'd1);

    // 5: saturation of err_cnt, then clear beating an increment
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    samp(4'b0000); samp(4'b0001);
    expect_out("s5_lock", 3'd1, 1, 0, 0, 1, 0, 2'd0);
    samp(4'b0110); expect_out("s5_err1", 3'd1, 0, 1, 0, 0, 0, 2'd1);
    samp(4'b0011); samp(4'b0111);
    expect_out("s5_relock1", 3'd3, 1, 0, 0, 1, 0, 2'd1);
    samp(4'b0000); expect_out("s5_err2", 3'd0, 1, 0, 1, 0, 0, 2'd2);
    samp(4'b0001); expect_out("s5_relock2", 3'd1, 1, 0, 0, 1, 0, 2'd2);
    samp(4'b0101); expect_out("s5_err3", 3'd1, 0, 1, 0, 0, 0, 2'd3);
    samp(4'b0011); samp(4'b0111);
    expect_out("s5_relock3", 3'd3, 1, 0, 0, 1, 0, 2'd3);
    samp(4'b0101); expect_out("s5_err4_sat", 3'd3, 0, 1, 0, 0, 0, 2'd3);
    samp(4'b1111); samp(4'b1110);
    expect_out("s5_relock4", 3'd5, 1, 0, 0, 1, 0, 2'd3);
    step(4'b0101, 1'b1, 1'b1, 1'b0);
    expect_out("s5_clr_wins", 3'd5, 0, 1, 0, 0, 0, 2'd0);

    // 6: reset mid-operation while locked with err_cnt=2
    samp(4'b1100); samp(4'b1000);
    expect_out("s6_lock", 3'd7, 1, 0, 0, 1, 0, 2'd0);
    samp(4'b0011); expect_out("s6_err1", 3'd2, 1, 0, 1, 0, 0, 2'd1);
    samp(4'b0111); expect_out("s6_relock1", 3'd3, 1, 0, 0, 1, 0, 2'd1);
    samp(4'b0101); expect_out("s6_err2", 3'd3, 0, 1, 0, 0, 0, 2'd2);
    samp(4'b1111); samp(4'b1110);
    expect_out("s6_relock2", 3'd5, 1, 0, 0, 1, 0, 2'd2);
    step(4'b1100, 1'b1, 1'b0, 1'b1);
    expect_out("s6_reset", 3'd0, 0, 0, 0, 0, 0, 2'd0);
    checks++;
    assert (fsm_state === HUNT) else begin
      errors++; $error("FAIL s6_state got %0d exp %0d", fsm_state, HUNT);
    end
    samp(4'b1100); expect_out("s6_hunt6", 3'd6, 1, 0, 0, 0, 0, 2'd0);
    samp(4'b1000); expect_out("s6_lock7", 3'd7, 1, 0, 0, 1, 0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
